// File: rtl/ula.sv
// 32-bit ALU driven by ex_stage; OP selects the operation, Zero_flag flags an all-zero result.
// Shifts take the amount from the low five bits of whichever operand the opcode names.
module ula (
  input  logic [3:0]  OP,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  output logic [31:0] result,
  output logic        Zero_flag
);

  always_comb begin
    result = 32'd0;
    unique case (OP)
      4'b0000: result = In1 + In2;
      4'b0001: result = In1 - In2;
      4'b0011: result = In1 & In2;
      4'b0101: result = In1 | In2;
      4'b0110: result = In1 ^ In2;
      4'b0100: result = ~(In1 | In2);
      4'b1110: result = {31'd0, $signed(In1) < $signed(In2)};
      4'b1111: result = {31'd0, In1 < In2};
      // Immediate shifts: amount in In1, data in In2.
      4'b0111: result = In2 << In1[4:0];
      4'b1001: result = In2 >> In1[4:0];
      4'b1100: result = $unsigned($signed(In2) >>> In1[4:0]);
      // Variable shifts: data in In1, amount in In2.
      4'b1000: result = In1 << In2[4:0];
      4'b1010: result = In1 >> In2[4:0];
      4'b1101: result = $unsigned($signed(In1) >>> In2[4:0]);
      default: result = 32'd0;
    endcase
  end

  assign Zero_flag = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU opcode decode, operand forwarding, EX/MEM register.
// Define EX_FORWARD_EN to compile in EX/MEM and WB forwarding; otherwise operands come from ID/EX.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [2:0]  id_class,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_shamt,
  input  logic        id_use_imm,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs_idx,
  input  logic [4:0]  id_rt_idx,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [4:0]  id_dst_idx,
  input  logic        wb_we,
  input  logic [4:0]  wb_idx,
  input  logic [31:0] wb_data,
  output logic        exm_valid,
  output logic [31:0] exm_result,
  output logic        exm_zero,
  output logic [31:0] exm_store_data,
  output logic [4:0]  exm_dst_idx,
  output logic        ex_illegal
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpOr   = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b1110;
  localparam logic [3:0] OpSltu = 4'b1111;
  localparam logic [3:0] OpSll  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1100;
  localparam logic [3:0] OpSllv = 4'b1000;
  localparam logic [3:0] OpSrlv = 4'b1010;
  localparam logic [3:0] OpSrav = 4'b1101;

  // ID/EX pipeline register
  logic        valid_q;
  logic [2:0]  class_q;
  logic [5:0]  funct_q;
  logic [4:0]  shamt_q;
  logic        use_imm_q;
  logic [31:0] imm_q;
  logic [4:0]  rs_idx_q;
  logic [4:0]  rt_idx_q;
  logic [31:0] rs_val_q;
  logic [31:0] rt_val_q;
  logic [4:0]  dst_idx_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q   <= 1'b0;
      class_q   <= 3'd0;
      funct_q   <= 6'd0;
      shamt_q   <= 5'd0;
      use_imm_q <= 1'b0;
      imm_q     <= 32'd0;
      rs_idx_q  <= 5'd0;
      rt_idx_q  <= 5'd0;
      rs_val_q  <= 32'd0;
      rt_val_q  <= 32'd0;
      dst_idx_q <= 5'd0;
    end else if (!stall) begin
      valid_q   <= id_valid;
      class_q   <= id_class;
      funct_q   <= id_funct;
      shamt_q   <= id_shamt;
      use_imm_q <= id_use_imm;
      imm_q     <= id_imm;
      rs_idx_q  <= id_rs_idx;
      rt_idx_q  <= id_rt_idx;
      rs_val_q  <= id_rs_val;
      rt_val_q  <= id_rt_val;
      dst_idx_q <= id_dst_idx;
    end
  end

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

`ifdef EX_FORWARD_EN
  function automatic logic [31:0] fwd_sel(input logic [4:0] idx, input logic [31:0] reg_val);
    logic [31:0] val;
    val = reg_val;
    if (idx != 5'd0) begin
      if (exm_valid && exm_dst_idx == idx) begin
        val = exm_result;
      end else if (wb_we && wb_idx == idx) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    fwd_rs = fwd_sel(rs_idx_q, rs_val_q);
    fwd_rt = fwd_sel(rt_idx_q, rt_val_q);
  end
`else
  assign fwd_rs = rs_val_q;
  assign fwd_rt = rt_val_q;

  logic unused_fwd;
  assign unused_fwd = ^{wb_we, wb_idx, wb_data, rs_idx_q, rt_idx_q};
`endif

  logic [3:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        illegal;

  always_comb begin
    alu_op  = OpAdd;
    alu_in1 = fwd_rs;
    alu_in2 = use_imm_q ? imm_q : fwd_rt;
    illegal = 1'b0;
    unique case (class_q)
      3'd0: begin
        // R-type never takes the immediate, whatever use_imm says.
        alu_in2 = fwd_rt;
        unique case (funct_q)
          6'h20, 6'h21: alu_op = OpAdd;
          6'h22, 6'h23: alu_op = OpSub;
          6'h24:        alu_op = OpAnd;
          6'h25:        alu_op = OpOr;
          6'h26:        alu_op = OpXor;
          6'h27:        alu_op = OpNor;
          6'h2a:        alu_op = OpSlt;
          6'h2b:        alu_op = OpSltu;
          6'h00, 6'h02, 6'h03: begin
            alu_op  = (funct_q == 6'h00) ? OpSll : (funct_q == 6'h02) ? OpSrl : OpSra;
            alu_in1 = {27'd0, shamt_q};
          end
          6'h04, 6'h06, 6'h07: begin
            alu_op  = (funct_q == 6'h04) ? OpSllv : (funct_q == 6'h06) ? OpSrlv : OpSrav;
            alu_in1 = fwd_rt;
            alu_in2 = {27'd0, fwd_rs[4:0]};
          end
          default: begin
            alu_op  = OpAdd;
            illegal = valid_q;
          end
        endcase
      end
      3'd1: alu_op = OpAdd;
      3'd2: alu_op = OpSub;
      3'd3: alu_op = OpAnd;
      3'd4: alu_op = OpOr;
      3'd5: alu_op = OpXor;
      3'd6: alu_op = OpSlt;
      3'd7: alu_op = OpSltu;
      default: alu_op = OpAdd;
    endcase
  end

  assign ex_illegal = illegal;

  logic [31:0] alu_result;
  logic        alu_zero;

  ula u_ula (
    .OP        (alu_op),
    .In1       (alu_in1),
    .In2       (alu_in2),
    .result    (alu_result),
    .Zero_flag (alu_zero)
  );

  // EX/MEM pipeline register; a stall drains a bubble while ID/EX holds.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      exm_valid      <= 1'b0;
      exm_result     <= 32'd0;
      exm_zero       <= 1'b0;
      exm_store_data <= 32'd0;
      exm_dst_idx    <= 5'd0;
    end else begin
      exm_valid      <= valid_q & ~illegal;
      exm_result     <= alu_result;
      exm_zero       <= alu_zero;
      exm_store_data <= fwd_rt;
      exm_dst_idx    <= dst_idx_q;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; expectations follow the build's EX_FORWARD_EN setting.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [2:0]  id_class;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic        id_use_imm;
  logic [31:0] id_imm;
  logic [4:0]  id_rs_idx, id_rt_idx, id_dst_idx;
  logic [31:0] id_rs_val, id_rt_val;
  logic        wb_we;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        exm_valid, exm_zero, ex_illegal;
  logic [31:0] exm_result, exm_store_data;
  logic [4:0]  exm_dst_idx;

  int checks = 0;
  int errors = 0;

`ifdef EX_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  ex_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_class       (id_class),
    .id_funct       (id_funct),
    .id_shamt       (id_shamt),
    .id_use_imm     (id_use_imm),
    .id_imm         (id_imm),
    .id_rs_idx      (id_rs_idx),
    .id_rt_idx      (id_rt_idx),
    .id_rs_val      (id_rs_val),
    .id_rt_val      (id_rt_val),
    .id_dst_idx     (id_dst_idx),
    .wb_we          (wb_we),
    .wb_idx         (wb_idx),
    .wb_data        (wb_data),
    .exm_valid      (exm_valid),
    .exm_result     (exm_result),
    .exm_zero       (exm_zero),
    .exm_store_data (exm_store_data),
    .exm_dst_idx    (exm_dst_idx),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [2:0] c, input logic [5:0] f, input logic [4:0] sh,
                        input logic ui, input logic [31:0] imm, input logic [4:0] rsi,
                        input logic [4:0] rti, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [4:0] dst);
    id_valid   = 1'b1;
    id_class   = c;
    id_funct   = f;
    id_shamt   = sh;
    id_use_imm = ui;
    id_imm     = imm;
    id_rs_idx  = rsi;
    id_rt_idx  = rti;
    id_rs_val  = rsv;
    id_rt_val  = rtv;
    id_dst_idx = dst;
  endtask

  task automatic bubble();
    set_id(3'd0, 6'd0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    id_valid = 1'b0;
  endtask

  // Register index 0 never forwards, so these vectors behave the same in both builds.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [5:0] f,
                        input logic [4:0] sh, input logic ui, input logic [31:0] imm,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] exp);
    set_id(c, f, sh, ui, imm, 5'd0, 5'd0, rsv, rtv, 5'd20);
    step();
    bubble();
    step();
    check(tag, exm_result, exp);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_idx = 5'd0; wb_data = 32'd0;
    bubble();
    step();
    step();
    check("rst_valid", 32'(exm_valid), 32'd0);
    check("rst_result", exm_result, 32'd0);
    check("rst_zero", 32'(exm_zero), 32'd0);
    check("rst_store", exm_store_data, 32'd0);
    check("rst_dst", 32'(exm_dst_idx), 32'd0);
    reset = 1'b0;

    // add r3, r1(5), r2(6): result two edges after issue
    set_id(3'd0, 6'h20, 5'd0, 1'b0, 32'd0, 5'd1, 5'd2, 32'd5, 32'd6, 5'd3);
    step();
    bubble();
    check("add_not_yet", 32'(exm_valid), 32'd0);
    step();
    check("add_result", exm_result, 32'd11);
    check("add_zero", 32'(exm_zero), 32'd0);
    check("add_valid", 32'(exm_valid), 32'd1);
    check("add_dst", 32'(exm_dst_idx), 32'd3);
    check("add_store", exm_store_data, 32'd6);
    step();
    check("add_once", 32'(exm_valid), 32'd0);

    // addi $1,$0,3 ; sub $2,$1,$1 with stale register-file values 5 and 2
    set_id(3'd1, 6'd0, 5'd0, 1'b1, 32'd3, 5'd0, 5'd0, 32'd0, 32'd0, 5'd1);
    step();
    set_id(3'd0, 6'h22, 5'd0, 1'b0, 32'd0, 5'd1, 5'd1, 32'd5, 32'd2, 5'd2);
    step();
    check("addi_result", exm_result, 32'd3);
    check("addi_dst", 32'(exm_dst_idx), 32'd1);
    bubble();
    step();
    check("sub_result", exm_result, Fwd ? 32'd0 : 32'd3);
    check("sub_zero", 32'(exm_zero), Fwd ? 32'd1 : 32'd0);
    check("sub_store", exm_store_data, Fwd ? 32'd3 : 32'd2);

    run_op("sll", 3'd0, 6'h00, 5'd4, 1'b0, 32'd0, 32'd0, 32'h1, 32'h10);
    run_op("sllv", 3'd0, 6'h04, 5'd0, 1'b0, 32'd0, 32'h23, 32'h1, 32'h8);
    run_op("srl", 3'd0, 6'h02, 5'd8, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'h0080_0000);
    run_op("sra", 3'd0, 6'h03, 5'd4, 1'b0, 32'd0, 32'd0, 32'h8000_0000, 32'hF800_0000);
    run_op("srav", 3'd0, 6'h07, 5'd0, 1'b0, 32'd0, 32'h24, 32'h8000_0010, 32'hF800_0001);
    run_op("nor", 3'd0, 6'h27, 5'd0, 1'b0, 32'd0, 32'h0F0F_0000, 32'hFF, 32'hF0F0_FF00);
    run_op("r_ignores_imm", 3'd0, 6'h21, 5'd0, 1'b1, 32'd100, 32'd1, 32'd2, 32'd3);
    run_op("slt", 3'd6, 6'd0, 5'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_op("sltu", 3'd7, 6'd0, 5'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_op("sub_imm", 3'd2, 6'd0, 5'd0, 1'b1, 32'd3, 32'd10, 32'd99, 32'd7);
    check("sub_imm_store", exm_store_data, 32'd99);
    run_op("xor", 3'd5, 6'd0, 5'd0, 1'b0, 32'd0, 32'hFF00, 32'h0FF0, 32'hF0F0);
    run_op("and", 3'd3, 6'd0, 5'd0, 1'b0, 32'd0, 32'hFF00, 32'h0FF0, 32'h0F00);
    run_op("or", 3'd4, 6'd0, 5'd0, 1'b0, 32'd0, 32'hFF00, 32'h0FF0, 32'hFFF0);

    // Forward priority: EX/MEM r3=7 beats WB r3=9; then WB alone supplies r3
    set_id(3'd1, 6'd0, 5'd0, 1'b1, 32'd7, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3);
    step();
    set_id(3'd0, 6'h20, 5'd0, 1'b0, 32'd0, 5'd3, 5'd0, 32'd1, 32'd0, 5'd4);
    wb_we = 1'b1; wb_idx = 5'd3; wb_data = 32'd9;
    step();
    set_id(3'd0, 6'h20, 5'd0, 1'b0, 32'd0, 5'd3, 5'd0, 32'd1, 32'd0, 5'd5);
    step();
    check("fwd_exm_prio", exm_result, Fwd ? 32'd7 : 32'd1);
    bubble();
    step();
    check("fwd_wb", exm_result, Fwd ? 32'd9 : 32'd1);
    wb_we = 1'b0;

    // Two-cycle stall with WB data for r1 arriving while held
    set_id(3'd1, 6'd0, 5'd0, 1'b0, 32'd0, 5'd1, 5'd2, 32'd10, 32'd20, 5'd6);
    step();
    bubble();
    stall = 1'b1;
    wb_we = 1'b1; wb_idx = 5'd1; wb_data = 32'd100;
    step();
    check("stall_bubble1", 32'(exm_valid), 32'd0);
    step();
    check("stall_bubble2", 32'(exm_valid), 32'd0);
    stall = 1'b0;
    step();
    check("stall_retire_v", 32'(exm_valid), 32'd1);
    check("stall_retire_r", exm_result, Fwd ? 32'd120 : 32'd30);
    wb_we = 1'b0;
    step();
    check("stall_retire_once", 32'(exm_valid), 32'd0);

    // Flush together with stall drops the instruction
    set_id(3'd1, 6'd0, 5'd0, 1'b0, 32'd0, 5'd1, 5'd2, 32'd4, 32'd4, 5'd7);
    step();
    bubble();
    flush = 1'b1; stall = 1'b1;
    step();
    check("flush_stall_v", 32'(exm_valid), 32'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    check("flush_dropped_v", 32'(exm_valid), 32'd0);
    check("flush_dropped_r", exm_result, 32'd0);

    // Illegal funct
    set_id(3'd0, 6'h3F, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 32'd1, 32'd1, 5'd8);
    step();
    check("illegal_flag", 32'(ex_illegal), 32'd1);
    bubble();
    step();
    check("illegal_no_valid", 32'(exm_valid), 32'd0);
    check("illegal_clear", 32'(ex_illegal), 32'd0);

    // Reset mid-stream clears both registers even under stall
    set_id(3'd1, 6'd0, 5'd0, 1'b1, 32'd5, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9);
    step();
    bubble();
    reset = 1'b1; stall = 1'b1;
    step();
    check("midrst_exm", 32'(exm_valid), 32'd0);
    reset = 1'b0; stall = 1'b0;
    step();
    check("midrst_idex", 32'(exm_valid), 32'd0);
    check("midrst_dst", 32'(exm_dst_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
